cdc_pulse_sender: RTL and testbench

Source-side initiator of a four-phase req/ack handshake that carries discrete events from a packet-side pulse into another clock domain without loss. It rising-edge-detects `i_pulse` and queues events in a saturating pending counter. Each queued event is launched as one full req-high/ack-high/req-low/ack-low cycle. The block sits in the source clock domain of the Ethernet MAC, for example for statistics and event flags. It pairs with a destination-side receiver that synchronizes `o_req`, raises `i_ack` and reports one pulse per handshake.

---
 rtl/cdc_pulse_sender.sv | 136 +++++++++++++
 tb/tb_cdc_pulse_sender.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_pulse_sender.sv
// Source-side initiator of a four-phase req/ack handshake: edge-detects i_pulse,
// queues events in a saturating counter and launches one full handshake per event.
module cdc_pulse_sender #(
    parameter int CNT_WIDTH      = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_pulse,
    output logic                 o_req,
    input  logic                 i_ack,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_pending,
    output logic                 o_sent,
    output logic                 o_overflow,
    output logic                 o_timeout,
    input  logic                 i_clear_status
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ_HIGH = 2'd1,
        REQ_LOW  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   launch;
    logic                   sent_next;
    logic                   pulse_rt;
    logic                   pulse_edge;
    logic                   full;
    logic                   drop;
    logic                   timeout_set;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [TW-1:0]          phase_cnt;

    // pulse_rt resets high so a level already high at reset release is not an event.
    assign pulse_edge = i_pulse & ~pulse_rt;
    assign ack_s      = ack_sync[SYNC_STAGES-1];
    assign full       = &o_pending;
    assign drop       = pulse_edge & full & ~launch;
    assign o_busy     = (state != IDLE);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pulse_rt <= 1'b1;
            ack_sync <= '0;
        end else begin
            pulse_rt <= i_pulse;
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], i_ack};
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        sent_next  = 1'b0;
        case (state)
            IDLE: begin
                if (o_pending != '0) begin
                    state_next = REQ_HIGH;
                    launch     = 1'b1;
                end
            end
            REQ_HIGH: begin
                if (ack_s) state_next = REQ_LOW;
            end
            REQ_LOW: begin
                if (!ack_s) begin
                    state_next = IDLE;
                    sent_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state  <= IDLE;
            o_req  <= 1'b0;
            o_sent <= 1'b0;
        end else begin
            state  <= state_next;
            o_req  <= (state_next == REQ_HIGH);
            o_sent <= sent_next;
        end
    end

    // An edge coinciding with a launch leaves the count unchanged; a full queue never wraps.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_pending <= '0;
        end else begin
            case ({pulse_edge, launch})
                2'b10:   if (!full) o_pending <= o_pending + CNT_WIDTH'(1);
                2'b01:   o_pending <= o_pending - CNT_WIDTH'(1);
                default: o_pending <= o_pending;
            endcase
        end
    end

    assign timeout_set = (TIMEOUT_CYCLES != 0) && (state != IDLE) &&
                         (state_next == state) && (phase_cnt == T_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            phase_cnt <= '0;
        end else if (state_next != state) begin
            phase_cnt <= '0;
        end else if ((state != IDLE) && (phase_cnt != T_LIMIT)) begin
            phase_cnt <= phase_cnt + TW'(1);
        end
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_overflow <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            if (drop)                o_overflow <= 1'b1;
            else if (i_clear_status) o_overflow <= 1'b0;
            if (timeout_set)         o_timeout  <= 1'b1;
            else if (i_clear_status) o_timeout  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdc_pulse_sender.sv
// Directed bench for cdc_pulse_sender: instance a (depth 15, timeout 16) and
// instance b (depth 3, timeout check disabled).
module tb_cdc_pulse_sender;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic       pulse_a, pulse_b, ack_a, ack_b, clr_a, clr_b;
    logic       req_a, req_b, busy_a, busy_b, sent_a, sent_b;
    logic       ovf_a, ovf_b, tmo_a, tmo_b;
    logic [3:0] pend_a;
    logic [1:0] pend_b;

    int checks = 0;
    int errors = 0;
    int n_sent_a = 0;
    int n_sent_b = 0;
    int base;

    always #5 clk = ~clk;

    cdc_pulse_sender #(.CNT_WIDTH(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_pulse(pulse_a), .o_req(req_a), .i_ack(ack_a),
        .o_busy(busy_a), .o_pending(pend_a), .o_sent(sent_a), .o_overflow(ovf_a),
        .o_timeout(tmo_a), .i_clear_status(clr_a)
    );

    cdc_pulse_sender #(.CNT_WIDTH(2), .SYNC_STAGES(2), .TIMEOUT_CYCLES(0)) dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_pulse(pulse_b), .o_req(req_b), .i_ack(ack_b),
        .o_busy(busy_b), .o_pending(pend_b), .o_sent(sent_b), .o_overflow(ovf_b),
        .o_timeout(tmo_b), .i_clear_status(clr_b)
    );

    always @(negedge clk) begin
        if (sent_a === 1'b1) n_sent_a = n_sent_a + 1;
        if (sent_b === 1'b1) n_sent_b = n_sent_b + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_req(input bit sel);
        return sel ? req_b : req_a;
    endfunction

    function automatic logic cur_sent(input bit sel);
        return sel ? sent_b : sent_a;
    endfunction

    task automatic set_ack(input bit sel, input logic v);
        if (sel) ack_b = v;
        else     ack_a = v;
    endtask

    task automatic pulse(input bit sel);
        if (sel) pulse_b = 1'b1; else pulse_a = 1'b1;
        tick();
        if (sel) pulse_b = 1'b0; else pulse_a = 1'b0;
        tick();
    endtask

    // Far-side model: ack 3 cycles after req rises, release 3 cycles after it falls.
    task automatic ack_cycle(input bit sel, input string tag);
        int n;
        n = 0;
        while (cur_req(sel) !== 1'b1 && n < 40) begin tick(); n++; end
        chk({tag, "_req_hi"}, 32'(cur_req(sel)), 32'd1);
        repeat (3) tick();
        set_ack(sel, 1'b1);
        n = 0;
        while (cur_req(sel) !== 1'b0 && n < 40) begin tick(); n++; end
        chk({tag, "_req_lo"}, 32'(cur_req(sel)), 32'd0);
        repeat (3) tick();
        set_ack(sel, 1'b0);
        n = 0;
        while (cur_sent(sel) !== 1'b1 && n < 40) begin tick(); n++; end
        chk({tag, "_sent"}, 32'(cur_sent(sel)), 32'd1);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        pulse_a = 1'b0; pulse_b = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0;
        repeat (3) tick();
        chk("rst_req",  32'(req_a),  32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_pend", 32'(pend_a), 32'd0);
        chk("rst_sent", 32'(sent_a), 32'd0);
        chk("rst_flags", 32'({ovf_a, tmo_a, ovf_b, tmo_b}), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick();
        chk("idle_req", 32'(req_a), 32'd0);

        // Single event with exact latencies.
        base = n_sent_a;
        pulse_a = 1'b1;
        tick();
        chk("se_pend1", 32'(pend_a), 32'd1);
        chk("se_req0",  32'(req_a),  32'd0);
        pulse_a = 1'b0;
        tick();
        chk("se_req1",  32'(req_a),  32'd1);
        chk("se_pend0", 32'(pend_a), 32'd0);
        chk("se_busy",  32'(busy_a), 32'd1);
        repeat (3) tick();
        ack_a = 1'b1;
        tick(); tick();
        chk("se_req_hold", 32'(req_a), 32'd1);
        tick();
        chk("se_req_fall", 32'(req_a), 32'd0);
        repeat (3) tick();
        ack_a = 1'b0;
        tick(); tick();
        chk("se_sent_early", 32'(sent_a), 32'd0);
        chk("se_busy_hold",  32'(busy_a), 32'd1);
        tick();
        chk("se_sent",  32'(sent_a), 32'd1);
        chk("se_idle",  32'(busy_a), 32'd0);
        tick();
        chk("se_sent_one", 32'(sent_a), 32'd0);
        chk("se_count", 32'(n_sent_a - base), 32'd1);
        chk("se_pend_end", 32'(pend_a), 32'd0);

        // Held level: one event only.
        base = n_sent_a;
        pulse_a = 1'b1;
        ack_cycle(1'b0, "held");
        repeat (35) tick();
        chk("held_req",  32'(req_a),  32'd0);
        chk("held_pend", 32'(pend_a), 32'd0);
        pulse_a = 1'b0;
        tick();
        chk("held_count", 32'(n_sent_a - base), 32'd1);

        // Burst while ack is stalled.
        base = n_sent_a;
        for (int i = 0; i < 5; i++) pulse(1'b0);
        chk("burst_pend4", 32'(pend_a), 32'd4);
        chk("burst_req",   32'(req_a),  32'd1);
        ack_cycle(1'b0, "burst0");
        tick();
        chk("b2b_req_rise", 32'(req_a), 32'd1);
        for (int i = 1; i < 5; i++) ack_cycle(1'b0, "burst");
        tick();
        chk("burst_count", 32'(n_sent_a - base), 32'd5);
        chk("burst_pend0", 32'(pend_a), 32'd0);
        chk("burst_ovf",   32'(ovf_a),  32'd0);

        // Timeout after 16 cycles in REQ_HIGH, then late ack completes.
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("to_clear0", 32'(tmo_a), 32'd0);
        pulse_a = 1'b1;
        tick();
        pulse_a = 1'b0;
        tick();
        chk("to_req", 32'(req_a), 32'd1);
        repeat (15) tick();
        chk("to_not_yet", 32'(tmo_a), 32'd0);
        tick();
        chk("to_set", 32'(tmo_a), 32'd1);
        chk("to_req_hold", 32'(req_a), 32'd1);
        base = n_sent_a;
        ack_cycle(1'b0, "to_late");
        tick();
        chk("to_late_count", 32'(n_sent_a - base), 32'd1);
        chk("to_sticky", 32'(tmo_a), 32'd1);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("to_cleared", 32'(tmo_a), 32'd0);

        // Asynchronous reset in REQ_HIGH with two queued events.
        for (int i = 0; i < 3; i++) pulse(1'b0);
        chk("mr_pend2", 32'(pend_a), 32'd2);
        chk("mr_req",   32'(req_a),  32'd1);
        #2;
        rst_a = 1'b1;
        pulse_a = 1'b1;
        #1;
        chk("mr_req_drop", 32'(req_a),  32'd0);
        chk("mr_pend",     32'(pend_a), 32'd0);
        chk("mr_busy",     32'(busy_a), 32'd0);
        tick(); tick();
        rst_a = 1'b0;
        repeat (4) tick();
        chk("mr_held_pend", 32'(pend_a), 32'd0);
        chk("mr_held_req",  32'(req_a),  32'd0);
        pulse_a = 1'b0;
        tick();
        pulse(1'b0);
        ack_cycle(1'b0, "post_rst");

        // Overflow on the 3-deep instance with ack stuck low.
        for (int i = 0; i < 4; i++) pulse(1'b1);
        chk("ov_pend3", 32'(pend_b), 32'd3);
        chk("ov_none",  32'(ovf_b),  32'd0);
        pulse(1'b1);
        chk("ov_set",   32'(ovf_b),  32'd1);
        chk("ov_sat",   32'(pend_b), 32'd3);
        pulse(1'b1);
        chk("ov_sat2",  32'(pend_b), 32'd3);
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        chk("ov_clear", 32'(ovf_b), 32'd0);
        tick();
        pulse_b = 1'b1;
        clr_b = 1'b1;
        tick();
        pulse_b = 1'b0;
        clr_b = 1'b0;
        chk("ov_set_wins", 32'(ovf_b),  32'd1);
        chk("ov_sat3",     32'(pend_b), 32'd3);
        repeat (40) tick();
        chk("tmo_disabled", 32'(tmo_b), 32'd0);
        base = n_sent_b;
        for (int i = 0; i < 4; i++) ack_cycle(1'b1, "ov_drain");
        repeat (5) tick();
        chk("ov_drain_count", 32'(n_sent_b - base), 32'd4);
        chk("ov_drain_pend",  32'(pend_b), 32'd0);
        chk("ov_drain_busy",  32'(busy_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
